// File: rtl/fft_ovl_framer_if.sv
// Sample-stream in / FFT-frame out bundle for the overlap-save framer.
interface fft_ovl_framer_if #(
  parameter int unsigned DW = 64
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic [7:0]    out_channel;
  logic [DW-1:0] out_data;
  logic          out_sof;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, out_channel, out_data, out_sof
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, out_channel, out_data, out_sof
  );
endinterface

// File: rtl/fft_ovl_framer.sv
// Overlap-save framer: each FFT_LEN frame replays the previous frame's last OVL
// samples (zeros at the start of an observation) followed by FFT_LEN-OVL new samples.
module fft_ovl_framer #(
  parameter int unsigned FFT_LEN = 1024,
  parameter int unsigned OVL     = 420,
  parameter int unsigned DW      = 64
) (
  input logic             clk,
  input logic             rst,
  fft_ovl_framer_if.slave bus
);
  localparam int unsigned PW = $clog2(FFT_LEN);
  localparam int unsigned AW = (OVL > 1) ? $clog2(OVL) : 1;
  localparam logic [PW-1:0] POS_LAST     = PW'(FFT_LEN - 1);
  localparam logic [PW-1:0] POS_RPL_LAST = PW'(OVL - 1);
  localparam logic [PW-1:0] POS_HIST     = PW'(FFT_LEN - OVL);

  typedef enum logic [1:0] {ST_IDLE, ST_REPLAY, ST_FILL, ST_PAD} state_e;

  logic [DW-1:0] hist_mem [OVL];

  state_e        state_q;
  logic [PW-1:0] pos_q;
  logic [PW-1:0] pos_d;
  logic [7:0]    frame_q;
  logic          hist_ok_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_sof_q;
  logic [7:0]    out_channel_q;
  logic [DW-1:0] out_data_q;

  logic          accept_c;
  logic          hist_we_c;
  logic [AW-1:0] hist_waddr_c;
  logic [AW-1:0] hist_raddr_c;

  assign pos_d        = pos_q + PW'(1);
  assign accept_c     = (state_q == ST_FILL) & bus.in_valid & in_ready_q;
  assign hist_we_c    = accept_c & (pos_q >= POS_HIST);
  assign hist_waddr_c = AW'(pos_q - POS_HIST);
  assign hist_raddr_c = AW'(pos_q);

  // Tail of each frame becomes the head of the next; OVL <= FFT_LEN/2 keeps
  // these writes clear of the replay reads.
  always_ff @(posedge clk) begin
    if (hist_we_c) begin
      hist_mem[hist_waddr_c] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pos_q         <= '0;
      frame_q       <= '0;
      hist_ok_q     <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_channel_q <= '0;
      out_data_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q <= ST_REPLAY;
            pos_q   <= '0;
          end
        end
        ST_REPLAY: begin
          out_valid_q   <= 1'b1;
          out_sof_q     <= (pos_q == '0);
          out_channel_q <= frame_q;
          out_data_q    <= hist_ok_q ? hist_mem[hist_raddr_c] : '0;
          pos_q         <= pos_d;
          if (pos_q == POS_RPL_LAST) begin
            state_q    <= ST_FILL;
            in_ready_q <= 1'b1;
          end
        end
        ST_FILL: begin
          if (accept_c) begin
            out_valid_q   <= 1'b1;
            out_channel_q <= frame_q;
            out_data_q    <= bus.in_data;
            pos_q         <= pos_d;
            if (pos_q == POS_LAST) begin
              in_ready_q <= 1'b0;
              if (bus.in_last) begin
                state_q   <= ST_IDLE;
                hist_ok_q <= 1'b0;
                frame_q   <= '0;
              end else begin
                state_q   <= ST_REPLAY;
                hist_ok_q <= 1'b1;
                frame_q   <= frame_q + 8'd1;
              end
            end else if (bus.in_last) begin
              state_q    <= ST_PAD;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_PAD: begin
          out_valid_q   <= 1'b1;
          out_channel_q <= frame_q;
          out_data_q    <= '0;
          pos_q         <= pos_d;
          if (pos_q == POS_LAST) begin
            state_q   <= ST_IDLE;
            hist_ok_q <= 1'b0;
            frame_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sof     = out_sof_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_data    = out_data_q;
endmodule

// File: tb/tb_fft_ovl_framer.sv
// Bench for fft_ovl_framer: transaction-level frame model plus directed spot values;
// a small second instance covers the 8-bit channel wrap.
module tb_fft_ovl_framer;
  localparam int unsigned L   = 1024;
  localparam int unsigned O   = 420;
  localparam int unsigned DW  = 64;
  localparam int unsigned SL  = 16;
  localparam int unsigned SO  = 4;
  localparam int unsigned SDW = 16;
  localparam int          CAP = 4096;
  localparam int          S_BEATS = 260 * SL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_ovl_framer_if #(.DW(DW)) bus ();
  fft_ovl_framer #(.FFT_LEN(L), .OVL(O), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  fft_ovl_framer_if #(.DW(SDW)) sbus ();
  fft_ovl_framer #(.FFT_LEN(SL), .OVL(SO), .DW(SDW)) sdut (.clk(clk), .rst(rst), .bus(sbus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame model: replay from model history, then accepted samples, then pad zeros.
  logic [63:0] mhist [O];
  logic [64:0] acc_q [$];
  int          mpos = 0;
  int          mframe = 0;
  bit          mhist_ok = 1'b0;
  bit          mpad = 1'b0;
  bit          mend = 1'b0;
  longint      cyc = 0;
  longint      last_cyc = 0;
  logic [63:0] e_data;
  logic [64:0] item;
  bit          is_real;

  logic [63:0] cap_d   [CAP];
  logic [7:0]  cap_ch  [CAP];
  logic        cap_sof [CAP];
  int          cap_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      is_real = 1'b0;
      e_data  = '0;
      if (mpos < int'(O)) begin
        e_data = mhist_ok ? mhist[mpos] : 64'd0;
        if (mpos != 0) check_eq("replay_contig", 64'(cyc - last_cyc), 64'd1);
      end else if (mpad) begin
        check_eq("pad_contig", 64'(cyc - last_cyc), 64'd1);
      end else if (acc_q.size() == 0) begin
        check_eq("extra_beat", 64'(acc_q.size()), 64'd1);
      end else begin
        item    = acc_q.pop_front();
        e_data  = item[63:0];
        is_real = 1'b1;
        if (item[64]) begin
          mend = 1'b1;
          if (mpos != int'(L) - 1) mpad = 1'b1;
        end
      end
      if (is_real && mpos >= int'(L - O)) mhist[mpos - int'(L - O)] = e_data;
      check_eq("data", bus.out_data, e_data);
      check_eq("chan", 64'(bus.out_channel), 64'(mframe % 256));
      check_eq("sof", 64'(bus.out_sof), 64'(mpos == 0));
      if (cap_n < CAP) begin
        cap_d[cap_n]   = bus.out_data;
        cap_ch[cap_n]  = bus.out_channel;
        cap_sof[cap_n] = bus.out_sof;
      end
      cap_n++;
      last_cyc = cyc;
      if (mpos == int'(L) - 1) begin
        mpos = 0;
        if (mend) begin
          mframe   = 0;
          mhist_ok = 1'b0;
        end else begin
          mframe   = (mframe + 1) % 256;
          mhist_ok = 1'b1;
        end
        mpad = 1'b0;
        mend = 1'b0;
      end else begin
        mpos++;
      end
    end
  end

  // Small instance: frame f, pos p carries 12f+p-4 (fill) or the previous tail (replay).
  int          sb_n = 0;
  int          sf;
  int          sp;
  logic [15:0] s_exp;

  always @(negedge clk) begin
    if (!rst && sbus.out_valid) begin
      sf = sb_n / int'(SL);
      sp = sb_n % int'(SL);
      if (sp < int'(SO)) s_exp = (sf == 0) ? 16'd0 : 16'(12 * sf - 4 + sp);
      else               s_exp = 16'(12 * sf + sp - 4);
      if (sb_n < S_BEATS) begin
        check_eq("s_data", 64'(sbus.out_data), 64'(s_exp));
        check_eq("s_chan", 64'(sbus.out_channel), 64'(sf % 256));
        check_eq("s_sof", 64'(sbus.out_sof), 64'(sp == 0));
      end
      sb_n++;
    end
  end

  task automatic do_reset(input string p);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    check_eq({p, "_rst_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({p, "_rst_sof"},   64'(bus.out_sof), 64'd0);
    check_eq({p, "_rst_chan"},  64'(bus.out_channel), 64'd0);
    check_eq({p, "_rst_data"},  bus.out_data, 64'd0);
    check_eq({p, "_rst_ready"}, 64'(bus.in_ready), 64'd0);
    acc_q.delete();
    mpos = 0; mframe = 0; mhist_ok = 1'b0; mpad = 1'b0; mend = 1'b0;
    cap_n = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int n, input longint start_k, input int idle_pct, input longint last_k);
    int     got = 0;
    int     budget = n * 4 + 4000;
    longint k = start_k;
    bit     v;
    while (got < n && budget > 0) begin
      @(negedge clk);
      v            = ($urandom_range(99) >= idle_pct);
      bus.in_valid = v;
      bus.in_data  = 64'(k);
      bus.in_last  = (k == last_k);
      if (v && bus.in_ready) begin
        acc_q.push_back({bus.in_last, bus.in_data});
        k++;
        got++;
      end
      budget--;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (got < n) check_eq("drive_timeout", 64'(got), 64'(n));
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int b = budget;
    while (cap_n < target && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    check_eq(tag, 64'(cap_n >= target), 64'd1);
  endtask

  task automatic check_run3(input string p);
    check_eq({p, "_beats"},  64'(cap_n), 64'd3492);
    check_eq({p, "_f0p0"},   cap_d[0], 64'd0);
    check_eq({p, "_f0sof"},  64'(cap_sof[0]), 64'd1);
    check_eq({p, "_f0p419"}, cap_d[419], 64'd0);
    check_eq({p, "_f0p421"}, cap_d[421], 64'd1);
    check_eq({p, "_f0p1023"}, cap_d[1023], 64'd603);
    check_eq({p, "_f1p0"},   cap_d[1024], 64'd184);
    check_eq({p, "_f1ch"},   64'(cap_ch[1024]), 64'd1);
    check_eq({p, "_f1sof"},  64'(cap_sof[1024]), 64'd1);
    check_eq({p, "_f1p419"}, cap_d[1443], 64'd603);
    check_eq({p, "_f1p420"}, cap_d[1444], 64'd604);
    check_eq({p, "_f1p1023"}, cap_d[2047], 64'd1207);
    check_eq({p, "_f2p0"},   cap_d[2048], 64'd788);
    check_eq({p, "_f2ch"},   64'(cap_ch[2048]), 64'd2);
    check_eq({p, "_f3p0"},   cap_d[3072], 64'd1392);
    check_eq({p, "_f3ch"},   64'(cap_ch[3072]), 64'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  sk;
    int  s_budget;
    bit  sacc;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    sbus.in_valid = 1'b0;
    sbus.in_last  = 1'b0;
    sbus.in_data  = '0;

    // full-rate stream
    do_reset("t1");
    drive(1812, 0, 0, -1);
    wait_beats(3492, 1000, "t1_wait");
    repeat (20) @(negedge clk);
    check_run3("t1");

    // 30% idle gaps give the same frames
    do_reset("t2");
    drive(1812, 0, 30, -1);
    wait_beats(3492, 1000, "t2_wait");
    repeat (20) @(negedge clk);
    check_run3("t2");

    // in_last mid-frame pads, then a fresh observation
    do_reset("t3");
    drive(701, 0, 0, 700);
    wait_beats(2048, 2000, "t3_wait");
    repeat (10) @(negedge clk);
    check_eq("t3_beats", 64'(cap_n), 64'd2048);
    check_eq("t3_p515", cap_d[1539], 64'd699);
    check_eq("t3_p516", cap_d[1540], 64'd700);
    check_eq("t3_pad0", cap_d[1541], 64'd0);
    check_eq("t3_padend", cap_d[2047], 64'd0);
    check_eq("t3_padch", 64'(cap_ch[2047]), 64'd1);
    check_eq("t3_idle_ready", 64'(bus.in_ready), 64'd0);
    check_eq("t3_idle_valid", 64'(bus.out_valid), 64'd0);
    drive(10, 5000, 0, -1);
    wait_beats(2478, 1000, "t3_wait2");
    check_eq("t3_n_p0", cap_d[2048], 64'd0);
    check_eq("t3_n_ch", 64'(cap_ch[2048]), 64'd0);
    check_eq("t3_n_sof", 64'(cap_sof[2048]), 64'd1);
    check_eq("t3_n_p419", cap_d[2467], 64'd0);
    check_eq("t3_n_p420", cap_d[2468], 64'd5000);
    check_eq("t3_n_p429", cap_d[2477], 64'd5009);

    // in_last on the final position: no pad
    do_reset("t4");
    drive(1208, 0, 0, 1207);
    wait_beats(2048, 1000, "t4_wait");
    repeat (10) @(negedge clk);
    check_eq("t4_beats", 64'(cap_n), 64'd2048);
    check_eq("t4_p1023", cap_d[2047], 64'd1207);
    check_eq("t4_ready", 64'(bus.in_ready), 64'd0);
    drive(5, 9000, 0, -1);
    wait_beats(2473, 1000, "t4_wait2");
    check_eq("t4_n_p0", cap_d[2048], 64'd0);
    check_eq("t4_n_ch", 64'(cap_ch[2048]), 64'd0);
    check_eq("t4_n_sof", 64'(cap_sof[2048]), 64'd1);
    check_eq("t4_n_p420", cap_d[2468], 64'd9000);

    // reset inside frame 1 replay; restart must not replay stale history
    do_reset("t5");
    drive(604, 0, 0, -1);
    wait_beats(1325, 2000, "t5_wait");
    check_eq("t5_f1p300", cap_d[1324], 64'd484);
    do_reset("t5mid");
    drive(200, 100, 0, -1);
    wait_beats(620, 1000, "t5_wait2");
    check_eq("t5_r_sof", 64'(cap_sof[0]), 64'd1);
    check_eq("t5_r_ch", 64'(cap_ch[0]), 64'd0);
    check_eq("t5_r_p300", cap_d[300], 64'd0);
    check_eq("t5_r_p420", cap_d[420], 64'd100);

    // channel wrap on the small instance, full rate
    sk = 0;
    sacc = 1'b0;
    s_budget = 6000;
    sbus.in_valid = 1'b1;
    while (sb_n < S_BEATS && s_budget > 0) begin
      @(negedge clk);
      if (sacc) sk++;
      sbus.in_data = 16'(sk);
      sacc = sbus.in_ready;
      s_budget--;
    end
    @(negedge clk);
    sbus.in_valid = 1'b0;
    check_eq("s_beats", 64'(sb_n >= S_BEATS), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
